// File: rtl/jtag_uart_pkg.sv
// ---------------------------------------------------------------------------
// jtag_uart_pkg
// Shared constants for the JTAG UART command receiver:
//   SYNC_BYTE   - frame start marker (0xA5)
//   RVALID_BIT  - bit index of RVALID in the JTAG UART data register
//   DATA_ADDR   - Avalon register select for the data register
//   ST_*        - poll FSM state encodings
//   PH_*        - frame assembler phase encodings
// ---------------------------------------------------------------------------
package jtag_uart_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         RVALID_BIT = 15;
    localparam logic       DATA_ADDR  = 1'b0;

    // Poll FSM states
    localparam logic [2:0] ST_POLL = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_EVAL = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    // Frame assembler phases
    localparam logic [1:0] PH_HUNT = 2'd0;
    localparam logic [1:0] PH_B0   = 2'd1;
    localparam logic [1:0] PH_B1   = 2'd2;
    localparam logic [1:0] PH_B2   = 2'd3;

endpackage

// File: rtl/jtag_uart_cmd_rx_if.sv
// ---------------------------------------------------------------------------
// jtag_uart_cmd_rx_if
// Avalon-MM read-only master bus towards the JTAG UART slave.
//   avm_read_n      - read strobe, active-low (master -> slave)
//   avm_address     - register select, always 0 (master -> slave)
//   avm_readdata    - data register contents (slave -> master)
//   avm_waitrequest - slave stall (slave -> master)
// Handshake: a read completes on the first clock edge that samples
// avm_read_n=0 together with avm_waitrequest=0; readdata is valid on
// that same edge.
// ---------------------------------------------------------------------------
interface jtag_uart_cmd_rx_if;

    logic        avm_read_n;
    logic        avm_address;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_read_n,
        output avm_address,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_read_n,
        input  avm_address,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/jtag_rx_frame_asm.sv
// ---------------------------------------------------------------------------
// jtag_rx_frame_asm
// Frame assembler: hunts for the 0xA5 sync byte, then collects 3 payload
// bytes MSB first. Non-sync bytes seen while hunting are counted
// (saturating at 255).
// Optional feature macro: JTAG_RX_TIMEOUT_EN -- drops a partial frame after
// TIMEOUT_CYCLES cycles without a byte and pulses timeout_o for one cycle.
// Ports:
//   clk_10MHz, reset_n - clock, async active-low reset
//   byte_valid_i       - one-cycle strobe, byte_i is a received byte
//   byte_i             - received byte
//   done_o             - combinational: this byte completes a word
//   word_o             - combinational: completed word (valid with done_o)
//   err_cnt_o          - discarded non-sync byte count, saturating
//   timeout_o          - one-cycle pulse when a partial frame is dropped
//   phase_o            - current phase (debug)
// ---------------------------------------------------------------------------
module jtag_rx_frame_asm
    import jtag_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_10MHz,
    input  logic        reset_n,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        done_o,
    output logic [23:0] word_o,
    output logic [7:0]  err_cnt_o,
    output logic        timeout_o,
    output logic [1:0]  phase_o
);

    logic [1:0]  phase_q, phase_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  err_q, err_d;
    logic        tmo_fire;

`ifdef JTAG_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q;

    // An arriving byte always wins over an expiring timeout so it is never lost.
    assign tmo_fire = !byte_valid_i && (phase_q != PH_HUNT) &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (byte_valid_i || (phase_q == PH_HUNT) || tmo_fire) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_10MHz or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= tmo_fire;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_fire  = 1'b0;
    // Feature compiled out: the output is a constant 0.
    assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        phase_d = phase_q;
        shift_d = shift_q;
        err_d   = err_q;
        if (byte_valid_i) begin
            case (phase_q)
                PH_HUNT: begin
                    if (byte_i == SYNC_BYTE) begin
                        phase_d = PH_B0;
                        shift_d = '0;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
                PH_B0: begin
                    shift_d = {shift_q[7:0], byte_i};
                    phase_d = PH_B1;
                end
                PH_B1: begin
                    shift_d = {shift_q[7:0], byte_i};
                    phase_d = PH_B2;
                end
                default: begin
                    phase_d = PH_HUNT;
                end
            endcase
        end else if (tmo_fire) begin
            phase_d = PH_HUNT;
            shift_d = '0;
        end
    end

    always_ff @(posedge clk_10MHz or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_HUNT;
            shift_q <= '0;
            err_q   <= '0;
        end else begin
            phase_q <= phase_d;
            shift_q <= shift_d;
            err_q   <= err_d;
        end
    end

    // The third payload byte is appended combinationally so the poll FSM can
    // register the whole word in the same edge that raises rx_valid.
    assign done_o    = byte_valid_i && (phase_q == PH_B2);
    assign word_o    = {shift_q, byte_i};
    assign err_cnt_o = err_q;
    assign phase_o   = phase_q;

endmodule

// File: rtl/jtag_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// jtag_uart_cmd_rx
// Polls a JTAG UART data register over Avalon-MM and assembles 0xA5-framed
// 3-byte command words. While a word waits for the consumer no reads are
// issued, so further bytes stay in the JTAG FIFO as backpressure.
// Optional feature macro: JTAG_RX_TIMEOUT_EN (inter-byte frame timeout).
// Ports:
//   clk_10MHz, reset_n - clock, async active-low reset
//   avm                - Avalon master bus (jtag_uart_cmd_rx_if.master)
//   rx_word            - assembled word, first payload byte in [23:16]
//   rx_valid/rx_ready  - word handshake: transfer when both sampled high;
//                        rx_word is stable while rx_valid=1
//   sync_err_cnt       - discarded non-sync bytes, saturating
//   rx_timeout         - one-cycle pulse when a partial frame times out
//   fsm_state_o        - poll FSM state (debug)
//   asm_phase_o        - assembler phase (debug)
// ---------------------------------------------------------------------------
module jtag_uart_cmd_rx
    import jtag_uart_pkg::*;
#(
    parameter int POLL_GAP       = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk_10MHz,
    input  logic                      reset_n,
    jtag_uart_cmd_rx_if.master        avm,
    output logic [23:0]               rx_word,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [7:0]                sync_err_cnt,
    output logic                      rx_timeout,
    output logic [2:0]                fsm_state_o,
    output logic [1:0]                asm_phase_o
);

    localparam int GAP_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

    logic [2:0]       state_q, state_d;
    logic             read_n_q, read_n_d;
    logic             rvalid_q, rvalid_d;
    logic [7:0]       byte_q, byte_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [23:0]      word_q, word_d;
    logic             valid_q, valid_d;

    logic             byte_valid;
    logic             asm_done;
    logic [23:0]      asm_word;
    logic             unused_readdata;

    assign unused_readdata = ^{avm.avm_readdata[31:16], avm.avm_readdata[14:8]};

    always_comb begin
        state_d    = state_q;
        read_n_d   = read_n_q;
        rvalid_d   = rvalid_q;
        byte_d     = byte_q;
        gap_d      = gap_q;
        word_d     = word_q;
        valid_d    = valid_q;
        byte_valid = 1'b0;
        case (state_q)
            ST_POLL: begin
                read_n_d = 1'b0;
                state_d  = ST_READ;
            end
            ST_READ: begin
                if (!avm.avm_waitrequest) begin
                    rvalid_d = avm.avm_readdata[RVALID_BIT];
                    byte_d   = avm.avm_readdata[7:0];
                    read_n_d = 1'b1;
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (!rvalid_q) begin
                    gap_d   = GAP_W'(POLL_GAP);
                    state_d = ST_GAP;
                end else begin
                    byte_valid = 1'b1;
                    if (asm_done) begin
                        word_d  = asm_word;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_POLL;
                    end
                end
            end
            ST_GAP: begin
                // Leaving on the cycle the count would reach 0 puts the next
                // read strobe POLL_GAP+2 cycles after the empty EVAL.
                if (gap_q > GAP_W'(1)) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    gap_d   = '0;
                    state_d = ST_POLL;
                end
            end
            ST_HOLD: begin
                if (rx_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_POLL;
                end
            end
            default: begin
                read_n_d = 1'b1;
                state_d  = ST_POLL;
            end
        endcase
    end

    always_ff @(posedge clk_10MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_POLL;
            read_n_q <= 1'b1;
            rvalid_q <= 1'b0;
            byte_q   <= '0;
            gap_q    <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            read_n_q <= read_n_d;
            rvalid_q <= rvalid_d;
            byte_q   <= byte_d;
            gap_q    <= gap_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
        end
    end

    jtag_rx_frame_asm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_asm (
        .clk_10MHz    (clk_10MHz),
        .reset_n      (reset_n),
        .byte_valid_i (byte_valid),
        .byte_i       (byte_q),
        .done_o       (asm_done),
        .word_o       (asm_word),
        .err_cnt_o    (sync_err_cnt),
        .timeout_o    (rx_timeout),
        .phase_o      (asm_phase_o)
    );

    assign avm.avm_read_n  = read_n_q;
    assign avm.avm_address = DATA_ADDR;
    assign rx_word         = word_q;
    assign rx_valid        = valid_q;
    assign fsm_state_o     = state_q;

endmodule

// File: tb/tb_jtag_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_jtag_uart_cmd_rx
// Directed bench: a small JTAG UART FIFO model answers Avalon reads, the
// stimulus walks through framing, sync errors, poll gap, waitrequest
// stretching, backpressure, saturation, reset and (when compiled in) the
// frame timeout.
// ---------------------------------------------------------------------------
module tb_jtag_uart_cmd_rx;

  localparam int POLL_GAP = 16;
  localparam int TMO      = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] rx_word;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  sync_err_cnt;
  logic        rx_timeout;
  logic [2:0]  fsm_state;
  logic [1:0]  asm_phase;

  jtag_uart_cmd_rx_if bus ();

  jtag_uart_cmd_rx #(
    .POLL_GAP       (POLL_GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_10MHz    (clk),
    .reset_n      (reset_n),
    .avm          (bus),
    .rx_word      (rx_word),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .sync_err_cnt (sync_err_cnt),
    .rx_timeout   (rx_timeout),
    .fsm_state_o  (fsm_state),
    .asm_phase_o  (asm_phase)
  );

  // clock block
  always #50 clk = ~clk;

  // JTAG UART FIFO model
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int reads_done = 0;
  int stall_req = 0;
  int stall_cnt = 0;
  int tmo_pulses = 0;
  int checks = 0;
  int failures = 0;

  assign bus.avm_readdata = (rd_ptr < wr_ptr) ?
    {16'(wr_ptr - rd_ptr), 1'b1, 7'b0, mem[rd_ptr]} : 32'h0;
  assign bus.avm_waitrequest = !bus.avm_read_n && (stall_cnt < stall_req);

  always @(posedge clk) begin
    if (!bus.avm_read_n) begin
      if (bus.avm_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        reads_done <= reads_done + 1;
        if (rd_ptr < wr_ptr) rd_ptr <= rd_ptr + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rx_timeout === 1'b1) tmo_pulses <= tmo_pulses + 1;
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rx_valid), 32'd1);
  endtask

  task automatic wait_drained(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (rd_ptr != wr_ptr && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rd_ptr == wr_ptr), 32'd1);
    cycles(5);
  endtask

  task automatic release_word(input string tag);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check(tag, 32'(rx_valid), 32'd0);
  endtask

  // waits for read_n to reach level lvl, then counts cycles it stays there
  task automatic run_length(input logic lvl, output int len);
    int n;
    n = 0;
    while (bus.avm_read_n !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    len = 0;
    while (bus.avm_read_n === lvl && len < 200) begin
      @(negedge clk);
      len++;
    end
  endtask

  initial begin
    int len;
    int low_cnt;
    int reads_snap;

    // reset block
    cycles(3);
    check("rst_read_n", 32'(bus.avm_read_n), 32'd1);
    check("rst_address", 32'(bus.avm_address), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_word", 32'(rx_word), 32'd0);
    check("rst_err", 32'(sync_err_cnt), 32'd0);
    check("rst_timeout", 32'(rx_timeout), 32'd0);
    reset_n = 1'b1;

    // basic frame
    push(8'hA5); push(8'h12); push(8'h34); push(8'h56);
    wait_valid("t1_valid", 300);
    check("t1_word", 32'(rx_word), 32'h123456);
    cycles(10);
    check("t1_hold_valid", 32'(rx_valid), 32'd1);
    check("t1_hold_word", 32'(rx_word), 32'h123456);
    check("t1_err", 32'(sync_err_cnt), 32'd0);
    release_word("t1_release");

    // sync errors, 0xA5 as payload
    push(8'h00); push(8'hFF); push(8'hA5); push(8'hA5); push(8'h01); push(8'h02);
    wait_valid("t2_valid", 300);
    check("t2_word", 32'(rx_word), 32'hA50102);
    check("t2_err", 32'(sync_err_cnt), 32'd2);
    release_word("t2_release");

    // empty reads: poll gap and read strobe width
    run_length(1'b0, len);
    run_length(1'b0, len);
    check("t3_low_width", 32'(len), 32'd1);
    run_length(1'b1, len);
    check("t3_gap_high", 32'(len), 32'(POLL_GAP + 2));
    run_length(1'b1, len);
    stall_req = 5;
    run_length(1'b0, len);
    check("t3_stall_low", 32'(len), 32'd6);
    stall_req = 0;

    // backpressure: no reads while a word is held
    push(8'hA5); push(8'h01); push(8'h02); push(8'h03);
    wait_valid("t4_valid", 300);
    push(8'hA5); push(8'hAA); push(8'hBB); push(8'hCC);
    reads_snap = reads_done;
    low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.avm_read_n === 1'b0) low_cnt++;
    end
    check("t4_hold_strobes", 32'(low_cnt), 32'd0);
    check("t4_hold_reads", 32'(reads_done - reads_snap), 32'd0);
    check("t4_hold_word", 32'(rx_word), 32'h010203);
    release_word("t4_release1");
    wait_valid("t4_valid2", 300);
    check("t4_word2", 32'(rx_word), 32'hAABBCC);
    release_word("t4_release2");

    // saturation of the sync error counter
    for (int i = 0; i < 300; i++) push((i % 2 == 0) ? 8'h5A : 8'h3C);
    wait_drained("t5_drained", 3000);
    check("t5_err_sat", 32'(sync_err_cnt), 32'd255);

    // reset mid-frame
    push(8'hA5); push(8'h77);
    wait_drained("t6_drained", 300);
    reset_n = 1'b0;
    #1;
    check("t6_read_n", 32'(bus.avm_read_n), 32'd1);
    check("t6_valid", 32'(rx_valid), 32'd0);
    check("t6_word", 32'(rx_word), 32'd0);
    check("t6_err", 32'(sync_err_cnt), 32'd0);
    check("t6_timeout", 32'(rx_timeout), 32'd0);
    cycles(2);
    reset_n = 1'b1;
    push(8'hA5); push(8'h01); push(8'h02); push(8'h03);
    wait_valid("t6_valid2", 300);
    check("t6_word2", 32'(rx_word), 32'h010203);
    check("t6_err2", 32'(sync_err_cnt), 32'd0);
    release_word("t6_release");

`ifdef JTAG_RX_TIMEOUT_EN
    // partial frame dropped by timeout
    push(8'hA5); push(8'h11);
    wait_drained("t7_drained", 300);
    cycles(30);
    check("t7_tmo_pulses", 32'(tmo_pulses), 32'd1);
    push(8'hA5); push(8'h01); push(8'h02); push(8'h03);
    wait_valid("t7_valid", 300);
    check("t7_word", 32'(rx_word), 32'h010203);
    release_word("t7_release");
`else
    check("t7_no_timeout", 32'(tmo_pulses), 32'd0);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_uart_cmd_rx.md
JTAG_UART_CMD_RX -- requirements
Module: jtag_uart_cmd_rx

Interface
REQ-001 The block SHALL have parameter POLL_GAP, default 16: idle cycles between reads after an empty read (RVALID=0).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000: inter-byte timeout inside a frame, used only when the timeout feature is compiled in.
REQ-003 The block SHALL have port clk_10MHz  in  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port avm_read_n  out  1  Avalon read strobe (active-low) to the JTAG UART slave.
REQ-006 The block SHALL have port avm_address  out  1  register select, constant 0 (data register).
REQ-007 The block SHALL have port avm_readdata  in  32  JTAG UART data register: [31:16] RAVAIL, [15] RVALID, [7:0] byte.
REQ-008 The block SHALL have port avm_waitrequest  in  1  Avalon wait; a read completes on the first cycle with read_n=0 and waitrequest=0.
REQ-009 The block SHALL have port rx_word  out  24  assembled word, big-endian (first payload byte in [23:16]).
REQ-010 The block SHALL have port rx_valid  out  1  rx_word holds a complete word.
REQ-011 The block SHALL have port rx_ready  in  1  consumer accepts the word; transfer occurs when rx_valid=1 and rx_ready=1 are sampled together.
REQ-012 The block SHALL have port sync_err_cnt  out  8  count of discarded non-sync bytes, saturating.
REQ-013 The block SHALL have port rx_timeout  out  1  one-cycle pulse when a partial frame is dropped by timeout.

Function
REQ-014 Frame format SHALL be sync byte 0xA5 followed by 3 payload bytes, MSB first; 0xA5 inside the payload SHALL be treated as data.
REQ-015 The poll FSM SHALL have states POLL, READ, EVAL, GAP, HOLD.
REQ-016 POLL: the block SHALL drive avm_read_n=0 (registered) and move to READ.
REQ-017 READ: the block SHALL hold avm_read_n=0 while waitrequest=1; on waitrequest=0 it SHALL capture readdata[15] and [7:0], drive avm_read_n=1 from the next cycle, and move to EVAL.
REQ-018 EVAL with RVALID=0: the block SHALL load a gap counter with POLL_GAP and move to GAP.
REQ-019 EVAL with RVALID=1: the byte SHALL go to the assembler; next state SHALL be HOLD if the byte completed a word, else POLL.
REQ-020 GAP: the counter SHALL decrement each cycle; at 0 the FSM SHALL move to POLL.
REQ-021 The assembler SHALL have phases HUNT, B0, B1, B2. HUNT: 0xA5 moves to B0; any other byte moves sync_err_cnt +1, saturating at 255. B0, B1, B2 SHALL shift the byte in; B2 SHALL return to HUNT.
REQ-022 On word completion, rx_word SHALL load the 3 bytes in the same cycle rx_valid rises (1 cycle after EVAL).
REQ-023 rx_word SHALL stay stable while rx_valid=1.
REQ-024 HOLD: the block SHALL issue no reads, leaving bytes in the JTAG FIFO as backpressure; on the transfer cycle rx_valid SHALL clear next cycle and the FSM SHALL move to POLL.
REQ-025 rx_ready while rx_valid=0 SHALL be ignored.
REQ-026 A captured byte SHALL never be dropped except by HUNT discard or timeout.
REQ-027 avm_address SHALL always be 0; the block SHALL never write.

Reset
REQ-028 reset_n=0 SHALL immediately force: FSM=POLL, assembler=HUNT, avm_read_n=1, rx_valid=0, rx_word=0, sync_err_cnt=0, rx_timeout=0, all counters 0.
REQ-029 Reset mid-read or mid-frame SHALL abandon the transaction and discard any partial word.

Configuration
REQ-030 Macro JTAG_RX_TIMEOUT_EN defined: a counter SHALL run while the assembler is in B0..B2 and clear on each accepted byte; on reaching TIMEOUT_CYCLES the assembler SHALL return to HUNT, the partial word SHALL be discarded, and rx_timeout SHALL pulse 1 cycle.
REQ-031 Macro JTAG_RX_TIMEOUT_EN undefined: no timeout counter, a partial frame SHALL wait indefinitely, and rx_timeout SHALL be tied 0.

Structure
REQ-032 A shared package jtag_uart_pkg SHALL hold the sync byte constant (0xA5), the RVALID bit index (15), the data register address (0), and the FSM state encodings.
REQ-033 A sub-module jtag_rx_frame_asm (HUNT/B0/B1/B2, error counter, timeout) SHALL be instantiated under the poll FSM.

Verification
REQ-034 Bytes A5 12 34 56 with waitrequest=0 -> rx_word=0x123456, rx_valid=1 until rx_ready.
REQ-035 Bytes 00 FF A5 A5 01 02 -> sync_err_cnt=2, rx_word=0xA50102.
REQ-036 RVALID=0 reads -> next avm_read_n low exactly POLL_GAP+2 cycles after the empty EVAL; waitrequest high 5 cycles -> read_n held low 6 cycles.
REQ-037 rx_ready=0 for 50 cycles after a word, then A5 AA BB CC queued -> zero reads during hold, then rx_word=0xAABBCC.
REQ-038 With JTAG_RX_TIMEOUT_EN, TIMEOUT_CYCLES=20: A5 11, then 25-cycle silence, then A5 01 02 03 -> one rx_timeout pulse, rx_word=0x010203.
REQ-039 300 non-sync bytes -> sync_err_cnt=255; reset_n pulse mid-frame -> all outputs return to reset values.
